// File: rtl/mem_arbiter_serial.sv
// mem_arbiter_serial: N_CH-channel byte-serial memory controller on one 8-bit
// RAM/IO port. Each granted request moves 1, 2 or 4 bytes, one per cycle,
// then returns a one-cycle done pulse (with err_out for illegal types).
// Build option: define MEMCTL_RR_ARB_EN for round-robin arbitration;
// otherwise channel 0 has fixed highest priority.
//
// state | meaning
// IDLE  | no transfer; arbitrate eligible channels
// XFER  | byte k of the granted request on the port (cnt_q = k)
// DONE  | done pulse for the granted channel; also arbitrates the next grant
module mem_arbiter_serial #(
  parameter int                N_CH    = 2,
  parameter int                ADDR_W  = 32,
  parameter logic [ADDR_W-1:0] IO_BASE = 'h30000
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic                   rdy_in,
  input  logic [N_CH-1:0]        req_in,
  input  logic [N_CH*ADDR_W-1:0] addr_in,
  input  logic [N_CH*32-1:0]     data_in,
  input  logic [N_CH-1:0]        r_nw_in,
  input  logic [N_CH*3-1:0]      type_in,
  input  logic                   flush_in,
  input  logic                   io_buffer_full,
  input  logic [7:0]             mem_read,
  output logic [7:0]             mem_write,
  output logic [ADDR_W-1:0]      mem_addr,
  output logic                   mem_r_nw,
  output logic [N_CH-1:0]        done_out,
  output logic                   err_out,
  output logic [31:0]            data_out,
  output logic [N_CH-1:0]        busy_out
);

  localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

  typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;

  state_t            state_q, state_d;
  logic [CH_W-1:0]   ch_q;
  logic [ADDR_W-1:0] base_q;
  logic [31:0]       wdata_q;
  logic              rnw_q;
  logic              sgn_q;
  logic              err_q;
  logic [1:0]        nbm1_q;
  logic [1:0]        cnt_q;
  logic [23:0]       acc_q;
  logic              rdy_q;
  logic [7:0]        hold_q;
  logic [7:0]        rd_byte;

  logic [N_CH-1:0]   io_wr;
  logic [N_CH-1:0]   elig;
  logic              gnt_v;
  logic [CH_W-1:0]   gnt_ch;
  logic [ADDR_W-1:0] sel_addr;
  logic [31:0]       sel_data;
  logic              sel_rnw;
  logic [2:0]        sel_type;
  logic              sel_legal;
  logic [1:0]        sel_nbm1;

`ifdef MEMCTL_RR_ARB_EN
  logic [CH_W-1:0]   rr_q;
  int                idx;
`endif

  function automatic logic type_legal(input logic [2:0] t, input logic rnw);
    logic ok;
    case (t)
      3'b000, 3'b001, 3'b010: ok = 1'b1;
      3'b101, 3'b110:         ok = rnw;
      default:                ok = 1'b0;
    endcase
    return ok;
  endfunction

  // A byte that arrived while the port was stalled is parked in hold_q, since
  // mem_read during a stall no longer reflects the address we need.
  assign rd_byte = rdy_q ? mem_read : hold_q;

  // Per-channel eligibility; IO writes wait while the IO sink is full.
  always_comb begin
    io_wr = '0;
    elig  = '0;
    for (int i = 0; i < N_CH; i++) begin
      io_wr[i] = (addr_in[i*ADDR_W +: ADDR_W] >= IO_BASE) && !r_nw_in[i];
      elig[i]  = req_in[i] && !done_out[i] && rdy_in && !flush_in &&
                 !(io_wr[i] && io_buffer_full);
    end
  end

  // Arbiter: pick one eligible channel.
  always_comb begin
    gnt_v  = 1'b0;
    gnt_ch = '0;
`ifdef MEMCTL_RR_ARB_EN
    idx = 0;
    for (int k = 0; k < N_CH; k++) begin
      idx = (int'(rr_q) + k) % N_CH;
      if (!gnt_v && elig[idx]) begin
        gnt_v  = 1'b1;
        gnt_ch = CH_W'(idx);
      end
    end
`else
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (elig[i]) begin
        gnt_v  = 1'b1;
        gnt_ch = CH_W'(i);
      end
    end
`endif
  end

  // Fields of the channel being granted.
  always_comb begin
    sel_addr  = addr_in[int'(gnt_ch)*ADDR_W +: ADDR_W];
    sel_data  = data_in[int'(gnt_ch)*32 +: 32];
    sel_rnw   = r_nw_in[gnt_ch];
    sel_type  = type_in[int'(gnt_ch)*3 +: 3];
    sel_legal = type_legal(sel_type, sel_rnw);
    case (sel_type[1:0])
      2'b00:   sel_nbm1 = 2'd3;
      2'b01:   sel_nbm1 = 2'd1;
      default: sel_nbm1 = 2'd0;
    endcase
  end

  // Next-state logic; DONE re-arbitrates so back-to-back grants have no gap.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: begin
        if (gnt_v) state_d = sel_legal ? XFER : DONE;
        else       state_d = IDLE;
      end
      XFER: begin
        if (flush_in && rnw_q)      state_d = IDLE;
        else if (cnt_q == nbm1_q)   state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, latched request fields and read assembly; everything holds while rdy_in=0.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q <= IDLE;
      ch_q    <= '0;
      base_q  <= '0;
      wdata_q <= '0;
      rnw_q   <= 1'b1;
      sgn_q   <= 1'b0;
      err_q   <= 1'b0;
      nbm1_q  <= '0;
      cnt_q   <= '0;
      acc_q   <= '0;
      rdy_q   <= 1'b0;
      hold_q  <= '0;
`ifdef MEMCTL_RR_ARB_EN
      rr_q    <= '0;
`endif
    end else begin
      rdy_q <= rdy_in;
      if (!rdy_in && rdy_q) hold_q <= mem_read;
      if (rdy_in) begin
        state_q <= state_d;
        if (state_q != XFER) begin
          if (gnt_v) begin
            ch_q    <= gnt_ch;
            base_q  <= sel_addr;
            wdata_q <= sel_data;
            rnw_q   <= sel_rnw;
            sgn_q   <= sel_type[2];
            err_q   <= !sel_legal;
            nbm1_q  <= sel_nbm1;
            cnt_q   <= '0;
            acc_q   <= '0;
`ifdef MEMCTL_RR_ARB_EN
            rr_q    <= (int'(gnt_ch) == N_CH - 1) ? '0 : gnt_ch + CH_W'(1);
`endif
          end
        end else begin
          cnt_q <= cnt_q + 2'd1;
          case (cnt_q)
            2'd1:    acc_q[7:0]   <= rd_byte;
            2'd2:    acc_q[15:8]  <= rd_byte;
            2'd3:    acc_q[23:16] <= rd_byte;
            default: ;
          endcase
        end
      end
    end
  end

  // Port and handshake outputs; the last read byte comes straight from the port.
  always_comb begin
    mem_addr  = '0;
    mem_r_nw  = 1'b1;
    mem_write = '0;
    done_out  = '0;
    busy_out  = '0;
    err_out   = 1'b0;
    data_out  = '0;
    case (state_q)
      XFER: begin
        mem_addr       = base_q + ADDR_W'(cnt_q);
        busy_out[ch_q] = 1'b1;
        if (rdy_in) begin
          mem_r_nw = rnw_q;
          if (!rnw_q) mem_write = wdata_q[{cnt_q, 3'b000} +: 8];
        end
      end
      DONE: begin
        done_out[ch_q] = 1'b1;
        err_out        = err_q;
        if (rnw_q && !err_q) begin
          case (nbm1_q)
            2'd3:    data_out = {rd_byte, acc_q};
            2'd1:    data_out = {{16{sgn_q & rd_byte[7]}}, rd_byte, acc_q[7:0]};
            default: data_out = {{24{sgn_q & rd_byte[7]}}, rd_byte};
          endcase
        end
      end
      default: ;
    endcase
  end

endmodule
